// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared segment types and the hex glyph table for the seven-segment scan driver
package seg7_pkg;

  // Segment vector, bit order {g,f,e,d,c,b,a}, logical polarity (1 = lit).
  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h00;

  localparam seg_t GLYPH_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic seg_t glyph_of(input logic [3:0] nibble);
    return GLYPH_TABLE[nibble];
  endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// rtl/seg7_hex_decoder.sv - combinational nibble to logical segment pattern
module seg7_hex_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output seg_t       seg
);

  always_comb begin
    seg = glyph_of(nibble);
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - multiplexed seven-segment driver with leading-zero blanking
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic                    load,
  input  logic                    blank_lz,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              cathode,
  output logic                    dp_out
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] TICK_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);
  localparam logic          POL       = (ACTIVE_LOW != 0);

  logic [CW-1:0]                 tick;
  logic [IW-1:0]                 idx;
  logic [NUM_DIGITS-1:0][3:0]    value_q;
  logic [NUM_DIGITS-1:0]         dp_q;
  logic [NUM_DIGITS-1:0]         lz_mask;
  logic [3:0]                    cur_nibble;
  logic                          cur_dp;
  logic                          cur_blank;
  seg_t                          glyph_seg;
  seg_t                          seg_logic;
  logic [NUM_DIGITS-1:0]         an_logic;

  // Refresh timebase and digit index; independent of load and blank_lz.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick <= '0;
      idx  <= '0;
    end else if (tick == TICK_LAST) begin
      tick <= '0;
      idx  <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      tick <= tick + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value_q <= '0;
      dp_q    <= '0;
    end else if (load) begin
      value_q <= value;
      dp_q    <= dp;
    end
  end

  // Digit k is a leading zero when it and every more significant nibble are zero.
  always_comb begin
    logic zero_run;
    lz_mask  = '0;
    zero_run = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      zero_run   = zero_run & (value_q[k] == 4'h0);
      lz_mask[k] = zero_run;
    end
  end

  always_comb begin
    cur_nibble = value_q[idx];
    cur_dp     = dp_q[idx];
    cur_blank  = blank_lz & lz_mask[idx];
  end

  seg7_hex_decoder u_dec (
    .nibble (cur_nibble),
    .seg    (glyph_seg)
  );

  always_comb begin
    seg_logic = cur_blank ? SEG_BLANK : glyph_seg;
    an_logic  = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx;
  end

  // Registered outputs; polarity is applied last so reset drives everything inactive.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an      <= {NUM_DIGITS{POL}};
      cathode <= {7{POL}};
      dp_out  <= POL;
    end else begin
      an      <= an_logic ^ {NUM_DIGITS{POL}};
      cathode <= seg_logic ^ {7{POL}};
      dp_out  <= cur_dp ^ POL;
    end
  end

endmodule
